node_step_sequencer: RTL and testbench

- Per-frame controller that sits directly upstream of the Node stage and drives its phase inputs verlet_state and fix_constraint_state, plus a constraint-iteration strobe for the link solver.
- After each completed frame it captures the Node's out_x/out_y into a snapshot register and offers it downstream on a valid/ready handshake.
- Queues one pending step request and counts any further requests it has to drop.

---
 rtl/node_step_sequencer.sv | 150 +++++++++++++++
 tb/tb_node_step_sequencer.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/node_step_sequencer.sv
// Per-frame phase sequencer for the Node stage: VERLET -> CONSTRAIN x ITERS -> FIX -> CAPTURE,
// then offers the captured node position on a valid/ready handshake and queues one extra request.
module node_step_sequencer #(
    parameter int WIDTH = 32,
    parameter int ITERS = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             step_req,
    input  logic [WIDTH-1:0] node_x,
    input  logic [WIDTH-1:0] node_y,
    input  logic             snap_ready,
    output logic             verlet_state,
    output logic             constraint_state,
    output logic [3:0]       iter_idx,
    output logic             fix_constraint_state,
    output logic             busy,
    output logic             snap_valid,
    output logic [WIDTH-1:0] snap_x,
    output logic [WIDTH-1:0] snap_y,
    output logic [CNT_W-1:0] frame_count,
    output logic [7:0]       drop_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_VERLET,
        S_CONSTRAIN,
        S_FIX,
        S_CAPTURE,
        S_WAIT_ACK
    } state_t;

    localparam logic [3:0] LAST_ITER = (ITERS == 0) ? 4'd0 : 4'(ITERS - 1);

    state_t             state_q, state_d;
    logic [3:0]         iter_q, iter_d;
    logic               pending_q, pending_d;
    logic [7:0]         drop_q, drop_d;
    logic [CNT_W-1:0]   frame_q, frame_d;
    logic [WIDTH-1:0]   snap_x_q, snap_x_d;
    logic [WIDTH-1:0]   snap_y_q, snap_y_d;
    logic               verlet_q, constraint_q, fix_q, busy_q, valid_q;

    always_comb begin
        // NOTE: every next-state value gets a default first so no path leaves it unassigned (no latches).
        state_d   = state_q;
        iter_d    = iter_q;
        pending_d = pending_q;
        drop_d    = drop_q;
        frame_d   = frame_q;
        snap_x_d  = snap_x_q;
        snap_y_d  = snap_y_q;

        // A request while a frame is in flight fills the single pending slot, else it is dropped.
        if (step_req && state_q != S_IDLE) begin
            if (pending_q) begin
                if (drop_q != 8'hFF) drop_d = drop_q + 8'd1;
            end else begin
                pending_d = 1'b1;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (step_req) state_d = S_VERLET;
            end
            S_VERLET: begin
                iter_d  = 4'd0;
                state_d = (ITERS == 0) ? S_FIX : S_CONSTRAIN;
            end
            S_CONSTRAIN: begin
                if (iter_q == LAST_ITER) begin
                    iter_d  = 4'd0;
                    state_d = S_FIX;
                end else begin
                    iter_d = iter_q + 4'd1;
                end
            end
            S_FIX: begin
                state_d = S_CAPTURE;
            end
            S_CAPTURE: begin
                snap_x_d = node_x;
                snap_y_d = node_y;
                state_d  = S_WAIT_ACK;
            end
            S_WAIT_ACK: begin
                if (snap_ready) begin
                    frame_d = frame_q + CNT_W'(1);
                    // A request arriving on the handshake cycle itself also starts the next frame at once.
                    if (pending_d) begin
                        pending_d = 1'b0;
                        state_d   = S_VERLET;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Phase outputs are registered from the next state so they line up with the state they describe.
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            state_q      <= S_IDLE;
            iter_q       <= 4'd0;
            pending_q    <= 1'b0;
            drop_q       <= 8'd0;
            frame_q      <= '0;
            snap_x_q     <= '0;
            snap_y_q     <= '0;
            verlet_q     <= 1'b0;
            constraint_q <= 1'b0;
            fix_q        <= 1'b0;
            busy_q       <= 1'b0;
            valid_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            iter_q       <= iter_d;
            pending_q    <= pending_d;
            drop_q       <= drop_d;
            frame_q      <= frame_d;
            snap_x_q     <= snap_x_d;
            snap_y_q     <= snap_y_d;
            verlet_q     <= (state_d == S_VERLET);
            constraint_q <= (state_d == S_CONSTRAIN);
            fix_q        <= (state_d == S_FIX);
            busy_q       <= (state_d != S_IDLE);
            valid_q      <= (state_d == S_WAIT_ACK);
        end
    end

    assign verlet_state         = verlet_q;
    assign constraint_state     = constraint_q;
    assign iter_idx             = iter_q;
    assign fix_constraint_state = fix_q;
    assign busy                 = busy_q;
    assign snap_valid           = valid_q;
    assign snap_x               = snap_x_q;
    assign snap_y               = snap_y_q;
    assign frame_count          = frame_q;
    assign drop_count           = drop_q;

endmodule

// File: tb/tb_node_step_sequencer.sv
// Directed bench for node_step_sequencer: ITERS=4 and ITERS=0 instances share one stimulus stream.
module tb_node_step_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        step_req;
    logic [31:0] node_x, node_y;
    logic        snap_ready;

    logic        ver4, con4, fix4, busy4, sv4;
    logic [3:0]  it4;
    logic [31:0] sx4, sy4;
    logic [15:0] fc4;
    logic [7:0]  dc4;

    logic        ver0, con0, fix0, busy0, sv0;
    logic [3:0]  it0;
    logic [31:0] sx0, sy0;
    logic [15:0] fc0;
    logic [7:0]  dc0;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    node_step_sequencer #(.WIDTH(32), .ITERS(4), .CNT_W(16)) dut4 (
        .clk(clk), .reset(reset), .step_req(step_req), .node_x(node_x), .node_y(node_y),
        .snap_ready(snap_ready), .verlet_state(ver4), .constraint_state(con4), .iter_idx(it4),
        .fix_constraint_state(fix4), .busy(busy4), .snap_valid(sv4), .snap_x(sx4), .snap_y(sy4),
        .frame_count(fc4), .drop_count(dc4)
    );

    node_step_sequencer #(.WIDTH(32), .ITERS(0), .CNT_W(16)) dut0 (
        .clk(clk), .reset(reset), .step_req(step_req), .node_x(node_x), .node_y(node_y),
        .snap_ready(snap_ready), .verlet_state(ver0), .constraint_state(con0), .iter_idx(it0),
        .fix_constraint_state(fix0), .busy(busy0), .snap_valid(sv0), .snap_x(sx0), .snap_y(sy0),
        .frame_count(fc0), .drop_count(dc0)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        req;
        logic        ver, con;
        logic [3:0]  it;
        logic        fix, busy, sv;
        logic [31:0] sx, sy;
        logic [15:0] fc;
        logic        ver0, con0, fix0, sv0, busy0;
        logic [15:0] fc0;
    } vec_t;

    vec_t vec[11];

    initial begin
        // cycle: req | ITERS=4: ver con it fix busy sv sx sy fc | ITERS=0: ver con fix sv busy fc
        vec[0]  = '{1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 32'd0,   32'd0,  16'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0};
        vec[1]  = '{1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 32'd0,   32'd0,  16'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'd0};
        vec[2]  = '{1'b0, 1'b0, 1'b1, 4'd0, 1'b0, 1'b1, 1'b0, 32'd0,   32'd0,  16'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'd0};
        vec[3]  = '{1'b0, 1'b0, 1'b1, 4'd1, 1'b0, 1'b1, 1'b0, 32'd0,   32'd0,  16'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'd0};
        vec[4]  = '{1'b0, 1'b0, 1'b1, 4'd2, 1'b0, 1'b1, 1'b0, 32'd0,   32'd0,  16'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'd0};
        vec[5]  = '{1'b0, 1'b0, 1'b1, 4'd3, 1'b0, 1'b1, 1'b0, 32'd0,   32'd0,  16'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd1};
        vec[6]  = '{1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 1'b0, 32'd0,   32'd0,  16'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd1};
        vec[7]  = '{1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 32'd0,   32'd0,  16'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd1};
        vec[8]  = '{1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b1, 32'd200, 32'd10, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd1};
        vec[9]  = '{1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 32'd200, 32'd10, 16'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd1};
        vec[10] = '{1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 32'd200, 32'd10, 16'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd1};

        reset = 1'b1; step_req = 1'b1; snap_ready = 1'b1;
        node_x = 32'd200; node_y = 32'd10;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        check("reset_drop_count", {24'd0, dc4}, 32'd0);
        check("reset_pending_idle", {31'd0, busy4}, 32'd0);

        // Single frame on both builds, snap_ready tied high.
        for (int k = 0; k < 11; k++) begin
            step_req = vec[k].req;
            check($sformatf("c%0d verlet4", k),     {31'd0, ver4},  {31'd0, vec[k].ver});
            check($sformatf("c%0d constrain4", k),  {31'd0, con4},  {31'd0, vec[k].con});
            check($sformatf("c%0d iter4", k),       {28'd0, it4},   {28'd0, vec[k].it});
            check($sformatf("c%0d fix4", k),        {31'd0, fix4},  {31'd0, vec[k].fix});
            check($sformatf("c%0d busy4", k),       {31'd0, busy4}, {31'd0, vec[k].busy});
            check($sformatf("c%0d valid4", k),      {31'd0, sv4},   {31'd0, vec[k].sv});
            check($sformatf("c%0d snap_x4", k),     sx4,            vec[k].sx);
            check($sformatf("c%0d snap_y4", k),     sy4,            vec[k].sy);
            check($sformatf("c%0d frames4", k),     {16'd0, fc4},   {16'd0, vec[k].fc});
            check($sformatf("c%0d verlet0", k),     {31'd0, ver0},  {31'd0, vec[k].ver0});
            check($sformatf("c%0d constrain0", k),  {31'd0, con0},  {31'd0, vec[k].con0});
            check($sformatf("c%0d fix0", k),        {31'd0, fix0},  {31'd0, vec[k].fix0});
            check($sformatf("c%0d valid0", k),      {31'd0, sv0},   {31'd0, vec[k].sv0});
            check($sformatf("c%0d busy0", k),       {31'd0, busy0}, {31'd0, vec[k].busy0});
            check($sformatf("c%0d frames0", k),     {16'd0, fc0},   {16'd0, vec[k].fc0});
            tick();
        end

        // Back-pressure: snapshot held while downstream stalls and node_x moves.
        snap_ready = 1'b0;
        step_req = 1'b1;
        tick();
        step_req = 1'b0;
        repeat (7) tick();
        for (int i = 0; i < 10; i++) begin
            check("stall_valid", {31'd0, sv4}, 32'd1);
            check("stall_snap_x", sx4, 32'd200);
            check("stall_frames", {16'd0, fc4}, 32'd1);
            node_x = 32'd300;
            tick();
        end
        snap_ready = 1'b1;
        check("release_valid", {31'd0, sv4}, 32'd1);
        tick();
        check("release_frames", {16'd0, fc4}, 32'd2);
        check("release_valid_low", {31'd0, sv4}, 32'd0);
        check("release_idle", {31'd0, busy4}, 32'd0);
        check("release_snap_x_held", sx4, 32'd200);

        // Queueing: requests at cycles 0,3,4,5 -> one pending, two dropped.
        for (int c = 0; c < 18; c++) begin
            step_req = (c == 0 || c == 3 || c == 4 || c == 5);
            if (c == 8) begin
                check("b2b_first_valid", {31'd0, sv4}, 32'd1);
                check("b2b_first_frames", {16'd0, fc4}, 32'd2);
            end
            if (c == 9) begin
                check("b2b_verlet_next", {31'd0, ver4}, 32'd1);
                check("b2b_busy_next", {31'd0, busy4}, 32'd1);
                check("b2b_frames_mid", {16'd0, fc4}, 32'd3);
            end
            if (c == 16) begin
                check("b2b_second_valid", {31'd0, sv4}, 32'd1);
                check("b2b_second_snap_x", sx4, 32'd300);
            end
            if (c == 17) begin
                check("b2b_idle_end", {31'd0, busy4}, 32'd0);
                check("b2b_frames_end", {16'd0, fc4}, 32'd4);
                check("b2b_drops", {24'd0, dc4}, 32'd2);
            end
            tick();
        end

        // Saturation: continuous requests while stalled.
        step_req = 1'b1;
        snap_ready = 1'b0;
        repeat (300) tick();
        step_req = 1'b0;
        check("sat_drops", {24'd0, dc4}, 32'd255);
        check("sat_valid", {31'd0, sv4}, 32'd1);
        check("sat_frames_before", {16'd0, fc4}, 32'd4);
        snap_ready = 1'b1;
        tick();
        snap_ready = 1'b0;
        check("sat_one_frame", {16'd0, fc4}, 32'd5);
        check("sat_pending_verlet", {31'd0, ver4}, 32'd1);
        repeat (10) tick();
        check("sat_still_one_frame", {16'd0, fc4}, 32'd5);
        check("sat_second_valid", {31'd0, sv4}, 32'd1);
        check("sat_drops_held", {24'd0, dc4}, 32'd255);
        snap_ready = 1'b1;
        tick();
        check("sat_drain_frames", {16'd0, fc4}, 32'd6);
        check("sat_drain_idle", {31'd0, busy4}, 32'd0);

        // Reset in the middle of CONSTRAIN, with a request pending.
        step_req = 1'b1;
        tick();
        step_req = 1'b0;
        tick();
        step_req = 1'b1;
        tick();
        step_req = 1'b0;
        tick();
        check("mid_iter_idx", {28'd0, it4}, 32'd2);
        check("mid_constrain", {31'd0, con4}, 32'd1);
        reset = 1'b1;
        step_req = 1'b1;
        tick();
        reset = 1'b0;
        step_req = 1'b0;
        check("rst_verlet", {31'd0, ver4}, 32'd0);
        check("rst_constrain", {31'd0, con4}, 32'd0);
        check("rst_iter", {28'd0, it4}, 32'd0);
        check("rst_fix", {31'd0, fix4}, 32'd0);
        check("rst_busy", {31'd0, busy4}, 32'd0);
        check("rst_valid", {31'd0, sv4}, 32'd0);
        check("rst_snap_x", sx4, 32'd0);
        check("rst_snap_y", sy4, 32'd0);
        check("rst_frames", {16'd0, fc4}, 32'd0);
        check("rst_drops", {24'd0, dc4}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_pending_cleared", {31'd0, busy4}, 32'd0);
        end
        step_req = 1'b1;
        tick();
        step_req = 1'b0;
        check("restart_verlet", {31'd0, ver4}, 32'd1);
        repeat (5) tick();
        check("restart_fix", {31'd0, fix4}, 32'd1);
        repeat (2) tick();
        check("restart_valid", {31'd0, sv4}, 32'd1);
        check("restart_snap_x", sx4, 32'd300);
        check("restart_snap_y", sy4, 32'd10);
        tick();
        check("restart_frames", {16'd0, fc4}, 32'd1);
        check("restart_idle", {31'd0, busy4}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // At most one phase strobe may be high in any cycle.
    always @(negedge clk) begin
        if (!reset && (int'(ver4) + int'(con4) + int'(fix4)) > 1) begin
            errors++;
            $display("FAIL phase_exclusive: got %0d strobes expected at most 1", int'(ver4) + int'(con4) + int'(fix4));
        end
    end

endmodule
